vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_if.sv | 27 ++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Display-fetch and CPU request/response bundle between the VRAM clients and vram_arbiter.
interface vram_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 8
);
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  disp_valid, disp_data, cpu_ack, cpu_rdata
    );

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output disp_valid, disp_data, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has fixed priority, CPU is served in free slots.
// Define VRAM_ARB_WBUF_EN for a 1-entry posted CPU write buffer with display-read forwarding.
module vram_arbiter #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    vram_arbiter_if.slave bus,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [1:0] TAG_NONE   = 2'd0;
    localparam logic [1:0] TAG_DISP   = 2'd1;
    localparam logic [1:0] TAG_CPU_RD = 2'd2;

    logic [0:0] state;
    logic [1:0] tag0;
    logic [1:0] tag1;
    logic       cpu_open;
    logic       cpu_issue;
    logic       write_ack;

`ifdef VRAM_ARB_WBUF_EN
    logic          wbuf_full;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    logic          drain;
    logic          cpu_post;
    logic          fwd_hit;
    logic          fwd0;
    logic          fwd1;
    logic [DW-1:0] fwd_data0;
    logic [DW-1:0] fwd_data1;
`endif

    always_comb begin
        cpu_open = (state == ST_IDLE) && bus.cpu_req;
`ifdef VRAM_ARB_WBUF_EN
        // Reads and writes both stall while the buffer is full so RAM order matches CPU order.
        drain     = wbuf_full && !bus.disp_req;
        cpu_issue = cpu_open && !bus.disp_req && !wbuf_full;
        cpu_post  = cpu_open && bus.cpu_we && bus.disp_req && !wbuf_full;
        fwd_hit   = bus.disp_req && wbuf_full && (wbuf_addr == bus.disp_addr);
        write_ack = (cpu_issue && bus.cpu_we) || cpu_post;
`else
        cpu_issue = cpu_open && !bus.disp_req;
        write_ack = cpu_issue && bus.cpu_we;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            tag0           <= TAG_NONE;
            tag1           <= TAG_NONE;
            ram_addr       <= '0;
            ram_we         <= 1'b0;
            ram_wdata      <= '0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
        end else begin
            ram_we <= 1'b0;
            tag0   <= TAG_NONE;
            tag1   <= tag0;

            if (bus.disp_req) begin
                ram_addr <= bus.disp_addr;
                tag0     <= TAG_DISP;
`ifdef VRAM_ARB_WBUF_EN
            end else if (drain) begin
                ram_addr  <= wbuf_addr;
                ram_we    <= 1'b1;
                ram_wdata <= wbuf_data;
`endif
            end else if (cpu_issue) begin
                ram_addr <= bus.cpu_addr;
                ram_we   <= bus.cpu_we;
                if (bus.cpu_we) begin
                    ram_wdata <= bus.cpu_wdata;
                end else begin
                    tag0 <= TAG_CPU_RD;
                end
            end

            // Read data returns to whichever source owns the tag two cycles after issue.
            bus.disp_valid <= (tag1 == TAG_DISP);
            if (tag1 == TAG_DISP) begin
`ifdef VRAM_ARB_WBUF_EN
                bus.disp_data <= fwd1 ? fwd_data1 : ram_rdata;
`else
                bus.disp_data <= ram_rdata;
`endif
            end

            bus.cpu_ack <= (tag1 == TAG_CPU_RD) || write_ack;
            if (tag1 == TAG_CPU_RD) begin
                bus.cpu_rdata <= ram_rdata;
            end

            // WAIT spans through the ack cycle so a held request is never granted twice.
            case (state)
                ST_IDLE: begin
`ifdef VRAM_ARB_WBUF_EN
                    if (cpu_issue || cpu_post) state <= ST_WAIT;
`else
                    if (cpu_issue) state <= ST_WAIT;
`endif
                end
                default: begin
                    if (bus.cpu_ack) state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VRAM_ARB_WBUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_full <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
            fwd0      <= 1'b0;
            fwd1      <= 1'b0;
            fwd_data0 <= '0;
            fwd_data1 <= '0;
        end else begin
            if (cpu_post) begin
                wbuf_full <= 1'b1;
                wbuf_addr <= bus.cpu_addr;
                wbuf_data <= bus.cpu_wdata;
            end else if (drain) begin
                wbuf_full <= 1'b0;
            end
            fwd0      <= fwd_hit;
            fwd_data0 <= wbuf_data;
            fwd1      <= fwd0;
            fwd_data1 <= fwd_data0;
        end
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic against a RAM shadow model.
module tb_vram_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [DW-1:0] mem [0:2047];

    logic [DW-1:0] ref_mem [0:2047];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int           due;
        logic [DW-1:0] data;
    } disp_exp_t;

    always #5 clk = ~clk;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        bus.disp_req  = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic settle(input int n);
        idle_bus();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic preload();
        for (int a = 0; a < 2048; a++) begin
            logic [DW-1:0] d;
            d = 8'($urandom_range(0, 255));
            if (a == 'h123) d = 8'h5A;
            if (a == 'h020) d = 8'hC3;
            load_en   = 1'b1;
            load_addr = a[AW-1:0];
            load_data = d;
            ref_mem[a] = d;
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 11'h123;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h020;
        tick();
        bus.disp_req = 1'b0;
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if ({ram_addr, ram_we, ram_wdata, bus.disp_valid, bus.disp_data, bus.cpu_ack, bus.cpu_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: addr=%h we=%b wdata=%h dv=%b dd=%h ack=%b rd=%h, required all 0",
                         k, ram_addr, ram_we, ram_wdata, bus.disp_valid, bus.disp_data, bus.cpu_ack, bus.cpu_rdata);
            end
        end
        rst = 1'b0;
        idle_bus();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus.cpu_ack !== 1'b0 || bus.disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_strobe cycle %0d: ack=%b valid=%b, required 0 0", k, bus.cpu_ack, bus.disp_valid);
            end
        end
    endtask

    task automatic test_disp_latency();
        bus.disp_req = 1'b1; bus.disp_addr = 11'h123;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.disp_req = 1'b0;
            if (k == 1) begin
                checks++;
                if (ram_addr !== 11'h123 || ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL disp_issue: addr=%h we=%b, required 123 0", ram_addr, ram_we);
                end
            end
            checks++;
            if (bus.disp_valid !== (k == 3)) begin
                errors++;
                $display("FAIL disp_valid_timing k=%0d: valid=%b, required %b", k, bus.disp_valid, (k == 3));
            end
            if (k >= 3) begin
                checks++;
                if (bus.disp_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL disp_data k=%0d: data=%h, required 5a", k, bus.disp_data);
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [DW-1:0] exp_d;
        exp_d = ref_mem[11'h010];
        bus.disp_req = 1'b1; bus.disp_addr = 11'h010;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h020;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.disp_req = 1'b0;
            if (k == 1 || k == 2) begin
                checks++;
                if (ram_addr !== ((k == 1) ? 11'h010 : 11'h020) || ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL conflict_issue k=%0d: addr=%h we=%b, required %h 0", k, ram_addr, ram_we,
                             (k == 1) ? 11'h010 : 11'h020);
                end
            end
            checks++;
            if (bus.cpu_ack !== (k == 4)) begin
                errors++;
                $display("FAIL conflict_ack k=%0d: ack=%b, required %b", k, bus.cpu_ack, (k == 4));
            end
            if (bus.cpu_ack === 1'b1) begin
                bus.cpu_req = 1'b0;
                checks++;
                if (bus.cpu_rdata !== 8'hC3) begin
                    errors++;
                    $display("FAIL conflict_rdata: rdata=%h, required c3", bus.cpu_rdata);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== exp_d) begin
                    errors++;
                    $display("FAIL conflict_disp: valid=%b data=%h, required 1 %h", bus.disp_valid, bus.disp_data, exp_d);
                end
            end
        end
        settle(2);
    endtask

    task automatic test_back_to_back();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h020;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.disp_req = (k == 1);
            bus.disp_addr = 11'h123;
            if (k == 1 || k == 2) begin
                checks++;
                if (ram_addr !== ((k == 1) ? 11'h020 : 11'h123)) begin
                    errors++;
                    $display("FAIL b2b_issue k=%0d: addr=%h, required %h", k, ram_addr, (k == 1) ? 11'h020 : 11'h123);
                end
            end
            checks++;
            if (bus.cpu_ack !== (k == 3) || bus.disp_valid !== (k == 4)) begin
                errors++;
                $display("FAIL b2b_strobes k=%0d: ack=%b valid=%b, required %b %b", k, bus.cpu_ack, bus.disp_valid,
                         (k == 3), (k == 4));
            end
            if (bus.cpu_ack === 1'b1) begin
                bus.cpu_req = 1'b0;
                checks++;
                if (bus.cpu_rdata !== 8'hC3) begin
                    errors++;
                    $display("FAIL b2b_rdata: rdata=%h, required c3", bus.cpu_rdata);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus.disp_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL b2b_disp_data: data=%h, required 5a", bus.disp_data);
                end
            end
        end
        settle(2);
    endtask

    task automatic test_write_then_display();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h300; bus.cpu_wdata = 8'h7E;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus.disp_req = (k == 2);
            bus.disp_addr = 11'h300;
            if (k == 1) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 11'h300 || ram_wdata !== 8'h7E) begin
                    errors++;
                    $display("FAIL wr_issue: we=%b addr=%h wdata=%h, required 1 300 7e", ram_we, ram_addr, ram_wdata);
                end
            end
            if (k <= 3) begin
                checks++;
                if (bus.cpu_ack !== (k == 1)) begin
                    errors++;
                    $display("FAIL wr_ack k=%0d: ack=%b, required %b", k, bus.cpu_ack, (k == 1));
                end
                if (bus.cpu_ack === 1'b1) bus.cpu_req = 1'b0;
            end
            if (k == 5) begin
                checks++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== 8'h7E) begin
                    errors++;
                    $display("FAIL wr_then_disp: valid=%b data=%h, required 1 7e", bus.disp_valid, bus.disp_data);
                end
            end
        end
        ref_mem[11'h300] = 8'h7E;
        settle(2);
    endtask

    task automatic test_starvation();
        int ack_k;
`ifdef VRAM_ARB_WBUF_EN
        ack_k = 1;
`else
        ack_k = 7;
`endif
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h155; bus.cpu_wdata = 8'hA7;
        bus.disp_req = 1'b1; bus.disp_addr = 11'($urandom_range(0, 2047));
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.disp_req = (k <= 5);
            bus.disp_addr = 11'($urandom_range(0, 2047));
            checks++;
            if (ram_we !== (k == 7)) begin
                errors++;
                $display("FAIL starve_we k=%0d: we=%b, required %b", k, ram_we, (k == 7));
            end
            if (k == 7) begin
                checks++;
                if (ram_addr !== 11'h155 || ram_wdata !== 8'hA7) begin
                    errors++;
                    $display("FAIL starve_write: addr=%h wdata=%h, required 155 a7", ram_addr, ram_wdata);
                end
            end
            checks++;
            if (bus.cpu_ack !== (k == ack_k)) begin
                errors++;
                $display("FAIL starve_ack k=%0d: ack=%b, required %b", k, bus.cpu_ack, (k == ack_k));
            end
            if (bus.cpu_ack === 1'b1) bus.cpu_req = 1'b0;
        end
        ref_mem[11'h155] = 8'hA7;
        settle(5);
    endtask

`ifdef VRAM_ARB_WBUF_EN
    task automatic test_wbuf();
        logic [DW-1:0] old_d;
        old_d = ref_mem[11'h050];
        bus.disp_req = 1'b1; bus.disp_addr = 11'h050;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 11'h040; bus.cpu_wdata = 8'h99;
        for (int k = 1; k <= 7; k++) begin
            tick();
            bus.disp_req = (k == 1);
            bus.disp_addr = 11'h040;
            checks++;
            if (bus.cpu_ack !== (k == 1 || k == 6)) begin
                errors++;
                $display("FAIL wbuf_ack k=%0d: ack=%b, required %b", k, bus.cpu_ack, (k == 1 || k == 6));
            end
            if (k == 1) begin
                bus.cpu_req = 1'b0;
            end
            if (k == 2) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'h040;
            end
            if (k == 3) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 11'h040 || ram_wdata !== 8'h99) begin
                    errors++;
                    $display("FAIL wbuf_drain: we=%b addr=%h wdata=%h, required 1 040 99", ram_we, ram_addr, ram_wdata);
                end
            end
            if (k == 4) begin
                checks++;
                if (ram_we !== 1'b0 || ram_addr !== 11'h040) begin
                    errors++;
                    $display("FAIL wbuf_read_issue: we=%b addr=%h, required 0 040", ram_we, ram_addr);
                end
            end
            checks++;
            if (bus.disp_valid !== (k == 3 || k == 4)) begin
                errors++;
                $display("FAIL wbuf_valid k=%0d: valid=%b, required %b", k, bus.disp_valid, (k == 3 || k == 4));
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (bus.disp_data !== ((k == 3) ? old_d : 8'h99)) begin
                    errors++;
                    $display("FAIL wbuf_disp_data k=%0d: data=%h, required %h", k, bus.disp_data,
                             (k == 3) ? old_d : 8'h99);
                end
            end
            if (k == 6) begin
                bus.cpu_req = 1'b0;
                checks++;
                if (bus.cpu_rdata !== 8'h99) begin
                    errors++;
                    $display("FAIL wbuf_rdata: rdata=%h, required 99", bus.cpu_rdata);
                end
            end
        end
        ref_mem[11'h040] = 8'h99;
        settle(3);
    endtask
`endif

    task automatic test_random_traffic();
        disp_exp_t     dq[$];
        bit            cpu_active;
        bit            cur_we;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_wdata;
        logic [DW-1:0] cur_exp;
        logic [AW-1:0] da;
        int            cpu_start;
        cpu_active = 1'b0;
        cpu_start  = 0;
        idle_bus();
        for (int c = 0; c < 600; c++) begin
            tick();
            if (bus.cpu_ack === 1'b1) begin
                checks++;
                if (!cpu_active) begin
                    errors++;
                    $display("FAIL rand_spurious_ack cycle %0d: ack=1, required 0", c);
                end else if (!cur_we && bus.cpu_rdata !== cur_exp) begin
                    errors++;
                    $display("FAIL rand_cpu_read cycle %0d addr %h: rdata=%h, required %h", c, cur_addr, bus.cpu_rdata, cur_exp);
                end
                if (cpu_active && cur_we) ref_mem[cur_addr] = cur_wdata;
                cpu_active  = 1'b0;
                bus.cpu_req = 1'b0;
            end
            if (dq.size() > 0 && dq[0].due == c) begin
                checks++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== dq[0].data) begin
                    errors++;
                    $display("FAIL rand_disp cycle %0d: valid=%b data=%h, required 1 %h", c, bus.disp_valid,
                             bus.disp_data, dq[0].data);
                end
                void'(dq.pop_front());
            end else if (bus.disp_valid === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rand_disp_unexpected cycle %0d: valid=1, required 0", c);
            end
            if (cpu_active && (c - cpu_start) > 60) begin
                checks++;
                errors++;
                $display("FAIL rand_cpu_timeout cycle %0d: no ack after %0d cycles, required ack", c, c - cpu_start);
                cpu_active  = 1'b0;
                bus.cpu_req = 1'b0;
            end

            bus.disp_req = (c < 560) && ((c % 8 == 0) || ($urandom_range(0, 15) == 0));
            if (bus.disp_req) begin
                da = 11'($urandom_range(0, 63));
                bus.disp_addr = da;
                dq.push_back('{due: c + 3, data: ref_mem[da]});
            end
            if (!cpu_active && bus.cpu_ack !== 1'b1 && c < 560 && $urandom_range(0, 2) == 0) begin
                cpu_active  = 1'b1;
                cpu_start   = c;
                cur_we      = 1'($urandom_range(0, 1));
                cur_addr    = 11'($urandom_range(0, 63));
                cur_wdata   = 8'($urandom_range(0, 255));
                cur_exp     = ref_mem[cur_addr];
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = cur_we;
                bus.cpu_addr  = cur_addr;
                bus.cpu_wdata = cur_wdata;
            end
        end
        checks++;
        if (dq.size() != 0 || cpu_active) begin
            errors++;
            $display("FAIL rand_drain: pending disp=%0d cpu_active=%b, required 0 0", dq.size(), cpu_active);
        end
        idle_bus();
    endtask

    initial begin
        rst           = 1'b1;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        preload();
        test_reset();
        test_disp_latency();
        test_conflict();
        test_back_to_back();
        test_write_then_display();
        test_starvation();
`ifdef VRAM_ARB_WBUF_EN
        test_wbuf();
`endif
        test_random_traffic();
        settle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
